// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DIV_W = 4;

    // Divide-by-zero quotient; slice the low W bits at the point of use.
    localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] partial,
    input  logic         next_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] new_partial,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W+1:0] trial;

    // The shifted partial keeps its top bit (W+1 wide) so a partial remainder
    // with its MSB set is not lost; the kept result always fits back in W bits.
    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted     = {partial, next_bit};
        trial       = {1'b0, shifted} - {2'b00, divisor};
        q_bit       = ~trial[W+1];
        new_partial = q_bit ? trial[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider with valid/ready handshakes on both sides.
// Define DIV_SIGNED_EN for two's-complement (truncating) division.
module seq_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(W) + 1;

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     partial_q;
    logic [W-1:0]     shift_q;
    logic [W-1:0]     divisor_q;
    logic [CNT_W-1:0] count_q;
    logic             zero_q;
    logic             last_step;

    logic [W-1:0]     new_partial;
    logic             q_bit;
    logic [W-1:0]     q_raw;
    logic [W-1:0]     dividend_mag;
    logic [W-1:0]     divisor_mag;
    logic [W-1:0]     q_final;
    logic [W-1:0]     r_final;

`ifdef DIV_SIGNED_EN
    logic             q_neg_q;
    logic             r_neg_q;
`endif

    div_step #(.W(W)) u_step (
        .partial     (partial_q),
        .next_bit    (shift_q[W-1]),
        .divisor     (divisor_q),
        .new_partial (new_partial),
        .q_bit       (q_bit)
    );

    assign last_step = (count_q == CNT_W'(W - 1));
    assign q_raw     = {shift_q[W-2:0], q_bit};

    // Magnitudes in, sign fix-up out; the fix-up sits on the result-register write.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dividend_mag = dividend[W-1] ? -dividend : dividend;
        divisor_mag  = divisor[W-1]  ? -divisor  : divisor;
        q_final      = q_neg_q ? -q_raw       : q_raw;
        r_final      = r_neg_q ? -new_partial : new_partial;
`else
        dividend_mag = dividend;
        divisor_mag  = divisor;
        q_final      = q_raw;
        r_final      = new_partial;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)                next_state = CALC;
            CALC:    if (zero_q || last_step)     next_state = DONE;
            DONE:    if (out_ready)               next_state = IDLE;
            default:                              next_state = IDLE;
        endcase
    end

    // Handshake flags decode the state register only, so no input reaches an output combinationally.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // A zero divisor spends one CALC cycle to register its fixed result,
    // which places its out_valid one edge after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            partial_q   <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        zero_q    <= (divisor == '0);
                        shift_q   <= (divisor == '0) ? dividend : dividend_mag;
                        divisor_q <= divisor_mag;
                        partial_q <= '0;
                        count_q   <= '0;
`ifdef DIV_SIGNED_EN
                        q_neg_q   <= dividend[W-1] ^ divisor[W-1];
                        r_neg_q   <= dividend[W-1];
`endif
                    end
                end
                CALC: begin
                    if (zero_q) begin
                        quotient    <= DIV_ZERO_Q[W-1:0];
                        remainder   <= shift_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        partial_q <= new_partial;
                        shift_q   <= q_raw;
                        count_q   <= count_q + CNT_W'(1);
                        if (last_step) begin
                            quotient    <= q_final;
                            remainder   <= r_final;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (unsigned, or signed with DIV_SIGNED_EN).
module tb_seq_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle = cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, measure latency from the acceptance edge, optionally
    // stall the consumer for `hold` cycles, then complete the result handshake.
    task automatic run_op(input vec_t v, input int hold, input string tag, output int e0);
        int waited;
        int lat;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " in_ready before issue"}, in_ready, 1);
        in_valid = 1'b1;
        dividend = v.a;
        divisor  = v.b;
        @(posedge clk);
        #1;
        e0       = cycle;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        lat = 0;
        if (v.lat > 1) check({tag, " in_ready busy"}, in_ready, 0);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, v.lat);
        check({tag, " quotient"}, quotient, v.q);
        check({tag, " remainder"}, remainder, v.r);
        check({tag, " div_by_zero"}, div_by_zero, v.dbz);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold out_valid"}, out_valid, 1);
            check({tag, " hold in_ready"}, in_ready, 0);
            check({tag, " hold quotient"}, quotient, v.q);
            check({tag, " hold remainder"}, remainder, v.r);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, out_valid, 0);
        check({tag, " in_ready after handshake"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   e0;
        int   prev_e0;
        int   prev_lat;

`ifdef DIV_SIGNED_EN
        vecs.push_back('{4'b1011, 4'b0110, 4'b0000, 4'b1011, 1'b0, 4}); // -5 / 6
        vecs.push_back('{4'b1111, 4'b0001, 4'b1111, 4'b0000, 1'b0, 4}); // -1 / 1
        vecs.push_back('{4'b0011, 4'b0111, 4'b0000, 4'b0011, 1'b0, 4}); //  3 / 7
        vecs.push_back('{4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b1, 1}); // -7 / 0
        vecs.push_back('{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 4}); // -7 / 2
        vecs.push_back('{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 4}); // -8 / -1
        vecs.push_back('{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 4}); //  7 / -2
`else
        vecs.push_back('{4'd11, 4'd6, 4'd1,  4'd5, 1'b0, 4});
        vecs.push_back('{4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4});
        vecs.push_back('{4'd3,  4'd7, 4'd0,  4'd3, 1'b0, 4});
        vecs.push_back('{4'd9,  4'd0, 4'd15, 4'd9, 1'b1, 1});
        vecs.push_back('{4'd15, 4'd8, 4'd1,  4'd7, 1'b0, 4});
        vecs.push_back('{4'd14, 4'd7, 4'd2,  4'd0, 1'b0, 4});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors issued back to back: each accept edge follows the
        // previous one by latency + 2 (handshake edge, then one IDLE edge).
        prev_e0  = 0;
        prev_lat = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], 0, $sformatf("vec%0d", i), e0);
            if (i > 0) check($sformatf("vec%0d issue interval", i), e0 - prev_e0, prev_lat + 2);
            prev_e0  = e0;
            prev_lat = vecs[i].lat;
        end

        // Backpressure: consumer stalls 5 cycles on 13 / 4.
`ifdef DIV_SIGNED_EN
        v = '{4'd13, 4'd4, 4'b0000, 4'b1101, 1'b0, 4};
`else
        v = '{4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4};
`endif
        run_op(v, 5, "backpressure", e0);

        // Reset two cycles into CALC of 14 / 3 aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            check("abort no out_valid", seen, 0);
        end

`ifdef DIV_SIGNED_EN
        v = '{4'd8, 4'd2, 4'b1100, 4'd0, 1'b0, 4};
`else
        v = '{4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 4};
`endif
        run_op(v, 0, "after_abort", e0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
